// File: rtl/updown_pkg.sv
// Shared definitions for the up/down/load counter: operation encoding and a
// parity helper used for the registered parity flag.
package updown_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_DOWN = 2'b01,
    OP_UP   = 2'b10,
    OP_HOLD = 2'b11
  } op_e;

  // Even-width callers zero-extend into 32 bits; extra zeros do not alter parity.
  function automatic logic parity32(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/updown_step.sv
// Combinational next-count evaluator: applies one load/up/down/hold operation
// with wrap-or-saturate handling and reports carry, borrow and load clamping.
module updown_step
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned UP_STEP = 3,
  parameter int unsigned DN_STEP = 5,
  parameter int unsigned MOD_MAX = 511
) (
  input  logic [WIDTH-1:0] count_i,
  input  op_e              op_i,
  input  logic             sat_mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] next_o,
  output logic             carry_o,
  output logic             borrow_o,
  output logic             load_err_o
);

  // All arithmetic is carried one bit wider than the count so that the
  // modulus M = MOD_MAX+1 (up to 2**WIDTH) and overflowing sums are exact.
  localparam logic [WIDTH:0] MAX_X     = (WIDTH+1)'(MOD_MAX);
  localparam logic [WIDTH:0] MOD_X     = MAX_X + (WIDTH+1)'(1);
  localparam logic [WIDTH:0] UP_X      = (WIDTH+1)'(UP_STEP);
  localparam logic [WIDTH:0] DN_X      = (WIDTH+1)'(DN_STEP);
  localparam logic [WIDTH:0] WRAP_DN_X = MOD_X - DN_X;

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] din_x;
  logic [WIDTH:0] sum_x;

  always_comb begin
    cnt_x      = {1'b0, count_i};
    din_x      = {1'b0, data_i};
    sum_x      = cnt_x + UP_X;
    next_o     = count_i;
    carry_o    = 1'b0;
    borrow_o   = 1'b0;
    load_err_o = 1'b0;

    case (op_i)
      OP_LOAD: begin
        if (din_x > MAX_X) begin
          next_o     = WIDTH'(MAX_X);
          load_err_o = 1'b1;
        end else begin
          next_o = data_i;
        end
      end
      OP_UP: begin
        if (sum_x > MAX_X) begin
          carry_o = 1'b1;
          next_o  = sat_mode_i ? WIDTH'(MAX_X) : WIDTH'(sum_x - MOD_X);
        end else begin
          next_o = WIDTH'(sum_x);
        end
      end
      OP_DOWN: begin
        if (cnt_x >= DN_X) begin
          next_o = WIDTH'(cnt_x - DN_X);
        end else begin
          borrow_o = 1'b1;
          // count - DN_STEP + M, reordered so no intermediate goes negative
          next_o   = sat_mode_i ? '0 : WIDTH'(cnt_x + WRAP_DN_X);
        end
      end
      OP_HOLD: begin
        next_o = count_i;
      end
      default: begin
        next_o = count_i;
      end
    endcase
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down/load counter with registered count, carry, borrow,
// parity, zero and load-error outputs; one register stage, async reset.
module updown_counter_param
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned UP_STEP   = 3,
  parameter int unsigned DN_STEP   = 5,
  parameter int unsigned MOD_MAX   = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << WIDTH) - 32'd1),
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             down,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count_out,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             parity_out,
  output logic             zero_out,
  output logic             load_err
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "updown_counter_param: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (WIDTH < 32 && MOD_MAX >= (32'd1 << WIDTH)) begin : g_bad_max
    $fatal(1, "updown_counter_param: MOD_MAX=%0d exceeds 2**WIDTH-1", MOD_MAX);
  end
  if (UP_STEP < 1 || UP_STEP > MOD_MAX) begin : g_bad_up
    $fatal(1, "updown_counter_param: UP_STEP=%0d outside 1..MOD_MAX", UP_STEP);
  end
  if (DN_STEP < 1 || DN_STEP > MOD_MAX) begin : g_bad_dn
    $fatal(1, "updown_counter_param: DN_STEP=%0d outside 1..MOD_MAX", DN_STEP);
  end
  if (RESET_VAL > MOD_MAX) begin : g_bad_rst
    $fatal(1, "updown_counter_param: RESET_VAL=%0d exceeds MOD_MAX", RESET_VAL);
  end

  localparam logic [WIDTH-1:0] RESET_W   = WIDTH'(RESET_VAL);
  localparam logic             RESET_PAR = ^RESET_W;
  localparam logic             RESET_ZRO = (RESET_W == '0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             parity_q, parity_d;
  logic             zero_q, zero_d;
  logic             lderr_q, lderr_d;

  logic [WIDTH-1:0] step_next;
  logic             step_carry;
  logic             step_borrow;
  logic             step_lderr;

  updown_step #(
    .WIDTH  (WIDTH),
    .UP_STEP(UP_STEP),
    .DN_STEP(DN_STEP),
    .MOD_MAX(MOD_MAX)
  ) u_step (
    .count_i   (count_q),
    .op_i      (op_e'({up, down})),
    .sat_mode_i(sat_mode),
    .data_i    (data_in),
    .next_o    (step_next),
    .carry_o   (step_carry),
    .borrow_o  (step_borrow),
    .load_err_o(step_lderr)
  );

  // Parity and zero are derived from the next count so they land in the same
  // edge as count_q and always describe the visible count.
  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    lderr_d  = 1'b0;
    if (enable) begin
      count_d  = step_next;
      carry_d  = step_carry;
      borrow_d = step_borrow;
      lderr_d  = step_lderr;
    end
    parity_d = parity32(32'(count_d));
    zero_d   = (count_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= RESET_W;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      parity_q <= RESET_PAR;
      zero_q   <= RESET_ZRO;
      lderr_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      parity_q <= parity_d;
      zero_q   <= zero_d;
      lderr_q  <= lderr_d;
    end
  end

  assign count_out  = count_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign parity_out = parity_q;
  assign zero_out   = zero_q;
  assign load_err   = lderr_q;

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down/load counter with configurable width, asymmetric step sizes, programmable modulus, and run-time wrap-or-saturate mode. All outputs are registered: count, carry, borrow, parity, zero and load-error flags. It is the general-purpose successor to the fixed 9-bit step-3/step-5 counter in the netlist-view examples. With default parameters in wrap mode it reproduces that counter's count, carry, borrow and parity cycle for cycle. It sits as a leaf block feeding datapath and status logic.

## Interface
- WIDTH, default 9: count width in bits; legal range 2..32.
- UP_STEP, default 3: increment per up operation; legal range 1..MOD_MAX.
- DN_STEP, default 5: decrement per down operation; legal range 1..MOD_MAX.
- MOD_MAX, default 2**WIDTH-1: highest legal count; the range is 0..MOD_MAX, and MOD_MAX ≤ 2**WIDTH-1.
- RESET_VAL, default 0: count value after reset; RESET_VAL ≤ MOD_MAX.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: when 0 the counter holds and all pulse flags are 0.
- up, input, 1: operation select, high bit.
- down, input, 1: operation select, low bit.
- sat_mode, input, 1: 0 = wrap at modulus; 1 = saturate at 0 and MOD_MAX.
- data_in, input, WIDTH: load value.
- count_out, output, WIDTH: registered count.
- carry_out, output, 1: one-cycle pulse when an up operation exceeds MOD_MAX.
- borrow_out, output, 1: one-cycle pulse when a down operation goes below 0.
- parity_out, output, 1: XOR-reduction of the next count, registered alongside it.
- zero_out, output, 1: high when the next count equals 0.
- load_err, output, 1: one-cycle pulse when a load value exceeds MOD_MAX.

## Operation
- Operation is selected by {up,down}, evaluated only when enable=1:
  - 00: load.
  - 01: down by DN_STEP.
  - 10: up by UP_STEP.
  - 11: hold.
- Arithmetic is done in WIDTH+1 bits and never truncates silently. Let M = MOD_MAX+1.
- Up: s = count+UP_STEP. If s ≤ MOD_MAX, next = s. Otherwise carry_out=1 and:
  - wrap: next = s−M.
  - saturate: next = MOD_MAX.
- Down: if count ≥ DN_STEP, next = count−DN_STEP. Otherwise borrow_out=1 and:
  - wrap: next = count−DN_STEP+M.
  - saturate: next = 0.
- Load: if data_in ≤ MOD_MAX, next = data_in. Otherwise next = MOD_MAX and load_err=1; this clamp applies in both modes.
- Hold (11, or enable=0): next = count. carry_out, borrow_out and load_err are all 0.
- Saturate mode, already at the limit: an up operation at MOD_MAX still asserts carry_out and stays at MOD_MAX; a down operation at 0 still asserts borrow_out and stays at 0.
- parity_out = ^next, and zero_out = (next==0). Both are registered in the same edge as count_out, so they always describe the current count_out.
- sat_mode is sampled every cycle and may change between any two operations; there is no hidden state.

## Timing
- Latency: inputs sampled at rising edge N appear on every output after edge N. Each flag pulse lasts exactly one cycle per qualifying operation.
- Repeated qualifying operations assert the flag on consecutive cycles.
- Reset, asynchronous, applied at any time including mid-operation:
  - count_out = RESET_VAL.
  - carry_out = borrow_out = load_err = 0.
  - parity_out = ^RESET_VAL.
  - zero_out = (RESET_VAL==0).
- The first operation after reset deasserts is the one sampled at the first rising edge with reset low.
- There is no state machine. The block has one register stage, and the only state is count_out plus the flag registers.
- The default configuration with sat_mode=0 is bit-exact with the legacy counter.

## Structure
- A shared package updown_pkg holds:
  - the operation encoding constants OP_LOAD=2'b00, OP_DOWN=2'b01, OP_UP=2'b10, OP_HOLD=2'b11;
  - a function computing parity.
- One combinational sub-module, updown_step, computes next, carry, borrow and load_err from count, the operation, sat_mode and data_in. The top level holds the registers, reset and enable gating.
- Parameter legality is checked at elaboration. An illegal combination is a fatal elaboration error.

## Test plan
- Reset: assert reset with RESET_VAL=0. Then count_out=0, zero_out=1, parity_out=0, and all pulse flags are 0. Asserting reset mid-count asynchronously returns count_out to 0.
- Wrap, up, defaults: load 510, then op 10. Expect count_out=1, carry_out=1 for one cycle, parity_out=1.
- Wrap, down: load 3, then op 01. Expect count_out=510 and borrow_out=1. A following hold (11) gives count_out=510 and borrow_out=0.
- Saturate, with MOD_MAX=99 and sat_mode=1:
  - load 98, then up → 99 with carry_out=1;
  - up again → 99 with carry_out=1;
  - load 2, then down → 0 with borrow_out=1 and zero_out=1.
- Load clamp, MOD_MAX=99: data_in=200 with op 00 gives count_out=99 and load_err=1. The next cycle's load of 50 gives 50 and load_err=0.
- Enable and legacy check: with enable=0, every op holds the count with no flags. A 1000-cycle random sequence of up, down and data_in under default parameters matches a model of the legacy step-3/step-5 counter on every output.
